// File: rtl/prescaler_multi.sv
// prescaler_multi: per-channel loadable divider producing a 50% duty clock and a half-period tick
module prescaler_multi #(
   parameter int N           = 22,
   parameter int CH          = 2,
   parameter int DIV_DEFAULT = 2**(N-1)-1
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic [CH-1:0] en,
   input  logic          sync,
   input  logic [CH-1:0] div_load,
   input  logic [N-1:0]  div_in,
   output logic [CH-1:0] clk_out,
   output logic [CH-1:0] tick
);
   for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [N-1:0] cnt, div;
      logic         co, tk;
      always_ff @(posedge clk_in or negedge rst_n)
         if (!rst_n) begin
            cnt <= '0;
            div <= N'(DIV_DEFAULT);
            co  <= 1'b0;
            tk  <= 1'b0;
         end else if (div_load[g]) begin
            div <= div_in;
            cnt <= '0;
            co  <= 1'b0;
            tk  <= 1'b0;
         end else if (sync) begin
            cnt <= '0;
            co  <= 1'b0;
            tk  <= 1'b0;
         end else if (!en[g]) begin
            tk  <= 1'b0;
         end else if (cnt == div) begin
            cnt <= '0;
            co  <= ~co;
            tk  <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
            tk  <= 1'b0;
         end
      assign clk_out[g] = co;
      assign tick[g]    = tk;
   end
endmodule

// File: tb/tb_prescaler_multi.sv
// tb_prescaler_multi: directed checks of reset, divide, load, sync, enable and async reset
module tb_prescaler_multi;
   localparam int N = 8, CH = 2;
   logic          clk_in = 1'b0, rst_n = 1'b0, sync = 1'b0;
   logic [CH-1:0] en = '0, div_load = '0, clk_out, tick;
   logic [N-1:0]  div_in = '0;
   int            total = 0, bad = 0;
   int            n, ft0, ft1;
   bit            ok;

   always #5 clk_in = ~clk_in;

   prescaler_multi #(.N(N), .CH(CH), .DIV_DEFAULT(127)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .sync(sync),
      .div_load(div_load), .div_in(div_in), .clk_out(clk_out), .tick(tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // edges until clk_out[ch] changes; ok means tick was low before and high on the toggle edge
   task automatic wait_toggle(input int ch, output int cyc, output bit good);
      logic start;
      start = clk_out[ch];
      cyc = -1;
      good = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (clk_out[ch] !== start) begin
            cyc = i;
            good = good && (tick[ch] === 1'b1);
            break;
         end else if (tick[ch] !== 1'b0) good = 1'b0;
      end
   endtask

   initial begin
      #12;
      chk("rst_clk", clk_out, 0);
      chk("rst_tick", tick, 0);
      #10;
      rst_n = 1'b1;
      en = 2'b11;
      // defaults: 128 low, 128 high
      wait_toggle(0, n, ok);
      chk("def_rise", n, 128);
      chk("def_rise_tick", ok, 1);
      chk("def_rise_lvl", clk_out, 2'b11);
      wait_toggle(0, n, ok);
      chk("def_fall", n, 128);
      chk("def_fall_tick", ok, 1);
      chk("def_fall_lvl", clk_out, 2'b00);
      // ch0 div=3
      div_in = 8'd3; div_load = 2'b01;
      step();
      div_load = 2'b00;
      chk("ld3_state", clk_out[0], 0);
      wait_toggle(0, n, ok);
      chk("ld3_rise", n, 4);
      chk("ld3_rise_tick", ok, 1);
      wait_toggle(0, n, ok);
      chk("ld3_fall", n, 4);
      chk("ld3_fall_tick", ok, 1);
      wait_toggle(1, n, ok);
      chk("ch1_unaff", n, 119);
      chk("ch1_unaff_lvl", clk_out[1], 1);
      // ch1 div=0
      div_in = 8'd0; div_load = 2'b10;
      step();
      div_load = 2'b00;
      chk("d0_load_clk", clk_out[1], 0);
      chk("d0_load_tick", tick[1], 0);
      step();
      chk("d0_c1_clk", clk_out[1], 1);
      chk("d0_c1_tick", tick[1], 1);
      step();
      chk("d0_c2_clk", clk_out[1], 0);
      chk("d0_c2_tick", tick[1], 1);
      step();
      chk("d0_c3_clk", clk_out[1], 1);
      en = 2'b01;
      step();
      chk("d0_frz_clk", clk_out[1], 1);
      chk("d0_frz_tick", tick[1], 0);
      step();
      chk("d0_frz2_clk", clk_out[1], 1);
      // ch0 div=3, ch1 div=5, then sync
      en = 2'b11; div_in = 8'd5; div_load = 2'b10;
      step();
      div_load = 2'b00;
      repeat (7) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_clk", clk_out, 0);
      chk("sync_tick", tick, 0);
      ft0 = -1; ft1 = -1;
      for (int s = 1; s <= 6; s++) begin
         step();
         if (tick[0] === 1'b1 && ft0 < 0) ft0 = s;
         if (tick[1] === 1'b1 && ft1 < 0) ft1 = s;
      end
      chk("sync_ft0", ft0, 4);
      chk("sync_ft1", ft1, 6);
      chk("sync_lvl", clk_out, 2'b11);
      wait_toggle(0, n, ok);
      chk("sync_keep0", n, 2);
      // load and sync together with en0 low
      en = 2'b10; div_in = 8'd9; div_load = 2'b01; sync = 1'b1;
      step();
      div_load = 2'b00; sync = 1'b0;
      chk("ls_clk", clk_out[0], 0);
      chk("ls_tick", tick[0], 0);
      ok = 1'b1;
      repeat (5) begin
         step();
         if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) ok = 1'b0;
      end
      chk("ls_idle", ok, 1);
      en = 2'b11;
      wait_toggle(0, n, ok);
      chk("ls_first", n, 10);
      chk("ls_first_tick", ok, 1);
      // async reset mid-count
      div_in = 8'd3; div_load = 2'b01;
      step();
      div_load = 2'b00;
      repeat (4) step();
      chk("ar_pre", {clk_out[0], tick[0]}, 2'b11);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_clk", clk_out, 0);
      chk("ar_tick", tick, 0);
      step();
      chk("ar_hold", clk_out, 0);
      #3 rst_n = 1'b1;
      wait_toggle(0, n, ok);
      chk("ar_div_def", n, 128);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
